cop_wr_queue: RTL

- Posted-write queue between the copper's MOVE master port and the system bus.
- Accepts copper register writes in one cycle, buffers them, and replays them as classic single write cycles on the system bus.
- Reports a "queue drained" flag that feeds the copper's WAIT/SKIP/JUMP que-empty condition input.
- Unresponsive targets are retired by a timeout, so the copper never hangs.

---
 rtl/cop_wr_queue_pkg.sv | 18 +
 rtl/cop_wr_fifo.sv | 59 +++++
 rtl/cop_wr_queue.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cop_wr_queue_pkg.sv
// Shared types for the copper posted-write queue: entry layout and master states.
// No logic; imported by the queue top and its FIFO.
package cop_wr_queue_pkg;

    localparam int ENTRY_W = 68;

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } cop_wr_entry_t;

    typedef enum logic {
        M_IDLE  = 1'b0,
        M_WRITE = 1'b1
    } m_state_t;

endpackage

// File: rtl/cop_wr_fifo.sv
// Synchronous FIFO in distributed RAM; head data is read combinationally.
// Latency: a push is visible at the head one cycle later.
// Backpressure: pushes while full and pops while empty are ignored.
module cop_wr_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 68
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [W-1:0]           push_dat_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_dat_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign full_o     = (r_count == CW'(DEPTH));
    assign empty_o    = (r_count == '0);
    assign count_o    = r_count;
    assign head_dat_o = r_mem[r_rd_ptr];
    assign w_push     = push_i & ~full_o;
    assign w_pop      = pop_i & ~empty_o;

    // Storage has no reset so it maps onto LUT RAM.
    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wr_ptr] <= push_dat_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cop_wr_queue.sv
// Posted-write queue: copper register writes are acked at once and replayed as bus writes.
// Latency: write accepted at edge N drives mcyc_o at edge N+1 when the queue is idle.
// Backpressure: sack_o is withheld while full; a silent target is retired after TIMEOUT cycles.
module cop_wr_queue #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   scyc_i,
    input  logic                   sstb_i,
    input  logic                   swe_i,
    input  logic [3:0]             ssel_i,
    input  logic [31:0]            sadr_i,
    input  logic [31:0]            sdat_i,
    output logic                   sack_o,
    output logic [31:0]            sdat_o,
    output logic                   mcyc_o,
    output logic                   mstb_o,
    output logic                   mwe_o,
    output logic [3:0]             msel_o,
    output logic [31:0]            madr_o,
    output logic [31:0]            mdat_o,
    input  logic                   mack_i,
    output logic                   que_empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   err_o,
    input  logic                   err_clr_i
);
    import cop_wr_queue_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    m_state_t      r_state;
    m_state_t      w_state_nxt;
    cop_wr_entry_t w_push_ent;
    cop_wr_entry_t w_head;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_load;
    logic          w_done;
    logic          w_tmo;
    logic [15:0]   r_tcnt;
    logic          r_sack;
    logic          r_mbus;
    logic [3:0]    r_msel;
    logic [31:0]   r_madr;
    logic [31:0]   r_mdat;
    logic          r_err;
    logic          r_que_empty;

    // Gating on r_sack keeps a strobe held across the ack cycle from being taken twice.
    assign w_wr_acc   = scyc_i & sstb_i & swe_i & ~w_full & ~r_sack;
    assign w_rd_acc   = scyc_i & sstb_i & ~swe_i & ~r_sack;
    assign w_push_ent = {ssel_i, sadr_i, sdat_i};

    cop_wr_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (w_wr_acc),
        .push_dat_i (w_push_ent),
        .pop_i      (w_done),
        .head_dat_o (w_head),
        .full_o     (w_full),
        .empty_o    (w_empty),
        .count_o    (w_count)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_state <= M_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            M_IDLE: begin
                if (!w_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = M_WRITE;
                end
            end
            M_WRITE: begin
                if (mack_i) begin
                    w_done      = 1'b1;
                    w_state_nxt = M_IDLE;
                end else if (r_tcnt == 16'(TIMEOUT - 1)) begin
                    w_done      = 1'b1;
                    w_tmo       = 1'b1;
                    w_state_nxt = M_IDLE;
                end
            end
            default: w_state_nxt = M_IDLE;
        endcase
    end

    // The head entry stays in the FIFO while on the bus; it is popped on ack or timeout.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_tcnt <= '0;
            r_mbus <= 1'b0;
            r_msel <= '0;
            r_madr <= '0;
            r_mdat <= '0;
        end else if (w_load) begin
            r_tcnt <= '0;
            r_mbus <= 1'b1;
            r_msel <= w_head.sel;
            r_madr <= w_head.adr;
            r_mdat <= w_head.dat;
        end else if (w_done) begin
            r_mbus <= 1'b0;
            r_msel <= '0;
        end else if (r_state == M_WRITE) begin
            r_tcnt <= r_tcnt + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sack      <= 1'b0;
            r_err       <= 1'b0;
            r_que_empty <= 1'b1;
        end else begin
            r_sack      <= w_wr_acc | w_rd_acc;
            r_que_empty <= (w_count == '0) && (r_state == M_IDLE);
            if (w_tmo || w_rd_acc)
                r_err <= 1'b1;
            else if (err_clr_i)
                r_err <= 1'b0;
        end
    end

    assign sack_o      = r_sack;
    assign sdat_o      = 32'h0;
    assign mcyc_o      = r_mbus;
    assign mstb_o      = r_mbus;
    assign mwe_o       = r_mbus;
    assign msel_o      = r_msel;
    assign madr_o      = r_madr;
    assign mdat_o      = r_mdat;
    assign que_empty_o = r_que_empty;
    assign count_o     = w_count;
    assign err_o       = r_err;

endmodule
